sa_rom_ctrl: RTL

- Sequencer and arbiter for the 8-byte station-address ROM (64-bit flat image; bytes 0-5 are the MAC address, bytes 6-7 the checksum).
- After reset it verifies the address checksum.
- After that it serves single-byte reads to two requesters: the Qbus register port (SA register reads) and the MAC address-filter loader.
- Holds the one shared byte-select path and grants it to one requester per cycle.

---
 rtl/sa_rom_if.sv | 22 ++
 rtl/sa_rom_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/sa_rom_if.sv
// Read handshake between the two station-address requesters (bus port, MAC
// filter loader) and the ROM controller.
interface sa_rom_if;
   logic       bus_req;
   logic [2:0] bus_idx;
   logic       bus_ack;
   logic [7:0] bus_data;
   logic       mac_req;
   logic [2:0] mac_idx;
   logic       mac_ack;
   logic [7:0] mac_data;

   modport master (
      output bus_req, bus_idx, mac_req, mac_idx,
      input  bus_ack, bus_data, mac_ack, mac_data
   );

   modport slave (
      input  bus_req, bus_idx, mac_req, mac_idx,
      output bus_ack, bus_data, mac_ack, mac_data
   );
endinterface

// File: rtl/sa_rom_ctrl.sv
// Station-address ROM sequencer: verifies the one's-complement checksum after
// reset/recheck, then arbitrates single-byte reads between bus and MAC ports.
module sa_rom_ctrl #(
   parameter bit MAC_PRIO = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [63:0] rom_q,
   input  logic        recheck,
   sa_rom_if.slave     port,
   output logic        sa_done,
   output logic        sa_ok
);

   typedef enum logic [1:0] {CHK, CMP, RUN} state_t;

   state_t      state_reg, state_next;
   logic [1:0]  cnt_reg, cnt_next;
   logic [15:0] acc_reg, acc_next;
   logic        bus_ack_reg, bus_ack_next;
   logic        mac_ack_reg, mac_ack_next;
   logic [7:0]  bus_data_reg, bus_data_next;
   logic [7:0]  mac_data_reg, mac_data_next;
   logic        done_reg, done_next;
   logic        ok_reg, ok_next;
   logic        rr_mac_reg, rr_mac_next;

   logic [7:0]  rom_byte [8];
   logic [15:0] rom_word [3];
   logic [15:0] word_sel;
   logic [16:0] sum17;
   logic [15:0] fold;
   logic        bus_elig, mac_elig;
   logic        grant_bus, grant_mac;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_byte
         assign rom_byte[gi] = rom_q[8*gi +: 8];
      end
      for (gi = 0; gi < 3; gi++) begin : g_word
         assign rom_word[gi] = {rom_byte[2*gi+1], rom_byte[2*gi]};
      end
   endgenerate

   always_comb begin
      word_sel = 16'h0000;
      case (cnt_reg)
         2'd0:    word_sel = rom_word[0];
         2'd1:    word_sel = rom_word[1];
         2'd2:    word_sel = rom_word[2];
         default: word_sel = 16'h0000;
      endcase
   end

   // End-around carry; the folded value cannot overflow a second time.
   assign sum17 = {1'b0, acc_reg} + {1'b0, word_sel};
   assign fold  = sum17[15:0] + {15'd0, sum17[16]};

   // A port whose ack is showing this cycle sits out this edge.
   assign bus_elig = port.bus_req && !bus_ack_reg;
   assign mac_elig = port.mac_req && !mac_ack_reg;

   always_comb begin
      grant_bus = 1'b0;
      grant_mac = 1'b0;
      if (state_reg == RUN && !recheck) begin
         if (bus_elig && mac_elig) begin
            if (MAC_PRIO || rr_mac_reg) grant_mac = 1'b1;
            else                        grant_bus = 1'b1;
         end else begin
            grant_bus = bus_elig;
            grant_mac = mac_elig;
         end
      end
   end

   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      acc_next      = acc_reg;
      bus_ack_next  = 1'b0;
      mac_ack_next  = 1'b0;
      bus_data_next = bus_data_reg;
      mac_data_next = mac_data_reg;
      done_next     = done_reg;
      ok_next       = ok_reg;
      rr_mac_next   = rr_mac_reg;

      if (recheck) begin
         state_next = CHK;
         cnt_next   = 2'd0;
         acc_next   = 16'h0000;
         done_next  = 1'b0;
         ok_next    = 1'b0;
      end else begin
         case (state_reg)
            CHK: begin
               acc_next = fold;
               if (cnt_reg == 2'd2) begin
                  state_next = CMP;
                  cnt_next   = 2'd0;
               end else begin
                  cnt_next = cnt_reg + 2'd1;
               end
            end
            CMP: begin
               ok_next    = (acc_reg == {rom_byte[7], rom_byte[6]});
               done_next  = 1'b1;
               state_next = RUN;
            end
            RUN: begin
               if (grant_bus) begin
                  bus_ack_next  = 1'b1;
                  bus_data_next = rom_byte[port.bus_idx];
                  rr_mac_next   = 1'b1;
               end
               if (grant_mac) begin
                  mac_ack_next  = 1'b1;
                  mac_data_next = rom_byte[port.mac_idx];
                  rr_mac_next   = 1'b0;
               end
            end
            default: state_next = CHK;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= CHK;
         cnt_reg      <= 2'd0;
         acc_reg      <= 16'h0000;
         bus_ack_reg  <= 1'b0;
         mac_ack_reg  <= 1'b0;
         bus_data_reg <= 8'h00;
         mac_data_reg <= 8'h00;
         done_reg     <= 1'b0;
         ok_reg       <= 1'b0;
         rr_mac_reg   <= 1'b0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         acc_reg      <= acc_next;
         bus_ack_reg  <= bus_ack_next;
         mac_ack_reg  <= mac_ack_next;
         bus_data_reg <= bus_data_next;
         mac_data_reg <= mac_data_next;
         done_reg     <= done_next;
         ok_reg       <= ok_next;
         rr_mac_reg   <= rr_mac_next;
      end
   end

   assign port.bus_ack  = bus_ack_reg;
   assign port.bus_data = bus_data_reg;
   assign port.mac_ack  = mac_ack_reg;
   assign port.mac_data = mac_data_reg;
   assign sa_done       = done_reg;
   assign sa_ok         = ok_reg;

endmodule
